// File: rtl/keystream_serializer.sv
// Keystream serializer: buffers finished ChaCha20 blocks in a two-entry ping-pong
// store and streams them out as OUT_W-bit beats under ready/valid handshaking.
module keystream_serializer #(
    parameter int unsigned OUT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0][3:0][31:0]  MatrixOut,
    input  logic                   serial_enable,
    output logic                   blk_accept,
    output logic [OUT_W-1:0]       ks_data,
    output logic                   ks_valid,
    input  logic                   ks_ready,
    output logic                   ks_last,
    output logic [31:0]            ks_block_idx,
    output logic                   overflow,
    input  logic                   clr_overflow,
    output logic                   idle
);

    localparam int unsigned BEATS = 512 / OUT_W;
    localparam int unsigned IDX_W = $clog2(BEATS);

    typedef enum logic {
        EMPTY,
        STREAM
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [1:0]         count_q;
    logic [1:0]         count_d;
    logic [IDX_W-1:0]   beat_q;
    logic               rd_slot_q;
    logic               wr_slot_q;
    logic [31:0]        seq_q;
    logic [1:0][511:0]  blk_q;
    logic [1:0][31:0]   tag_q;

    logic               pop;
    logic               last_beat;
    logic               final_pop;
    logic               capture;
    logic               drop;
    logic [511:0]       rd_blk;

    // Flattened block: word w sits at bits [32w +: 32], so byte k of the
    // little-endian serialization is simply bits [8k +: 8].
    assign rd_blk     = blk_q[rd_slot_q];
    assign blk_accept = (count_q < 2'd2);
    assign idle       = (count_q == 2'd0);
    assign ks_valid   = (state_q == STREAM);

    assign last_beat  = (beat_q == IDX_W'(BEATS - 1));
    assign pop        = ks_valid & ks_ready;
    assign final_pop  = pop & last_beat;
    assign capture    = serial_enable & (blk_accept | final_pop);
    assign drop       = serial_enable & ~blk_accept & ~final_pop;

    assign ks_data      = ks_valid ? rd_blk[beat_q * OUT_W +: OUT_W] : '0;
    assign ks_last      = ks_valid & last_beat;
    assign ks_block_idx = ks_valid ? tag_q[rd_slot_q] : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (capture) state_d = STREAM;
            STREAM:  if (final_pop && (count_q == 2'd1) && !capture) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({capture, final_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            beat_q    <= '0;
            rd_slot_q <= 1'b0;
            wr_slot_q <= 1'b0;
            seq_q     <= '0;
            overflow  <= 1'b0;
        end else begin
            count_q <= count_d;
            if (pop) begin
                beat_q <= final_pop ? '0 : beat_q + IDX_W'(1);
            end
            if (final_pop) begin
                rd_slot_q <= ~rd_slot_q;
            end
            if (capture) begin
                wr_slot_q <= ~wr_slot_q;
                seq_q     <= seq_q + 32'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // Payload storage needs no reset: occupancy gates every use of it.
    // When full, the slot being drained on its final beat equals wr_slot_q.
    always_ff @(posedge clk) begin
        if (capture) begin
            blk_q[wr_slot_q] <= MatrixOut;
            tag_q[wr_slot_q] <= seq_q;
        end
    end

endmodule

// File: tb/tb_keystream_serializer.sv
// Directed bench for keystream_serializer: one OUT_W=8 and one OUT_W=32 instance
// share the stimulus; each scenario checks the instance it targets.
module tb_keystream_serializer;

    logic                  clk;
    logic                  rst;
    logic [3:0][3:0][31:0] matrix;
    logic                  serial_enable;
    logic                  ks_ready;
    logic                  clr_overflow;

    logic        acc8, valid8, last8, ov8, idle8;
    logic [7:0]  data8;
    logic [31:0] idx8;
    logic        acc32, valid32, last32, ov32, idle32;
    logic [31:0] data32;
    logic [31:0] idx32;

    int n_checks = 0;
    int n_fail   = 0;

    keystream_serializer #(.OUT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .MatrixOut(matrix), .serial_enable(serial_enable),
        .blk_accept(acc8), .ks_data(data8), .ks_valid(valid8), .ks_ready(ks_ready),
        .ks_last(last8), .ks_block_idx(idx8), .overflow(ov8),
        .clr_overflow(clr_overflow), .idle(idle8)
    );

    keystream_serializer #(.OUT_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .MatrixOut(matrix), .serial_enable(serial_enable),
        .blk_accept(acc32), .ks_data(data32), .ks_valid(valid32), .ks_ready(ks_ready),
        .ks_last(last32), .ks_block_idx(idx32), .overflow(ov32),
        .clr_overflow(clr_overflow), .idle(idle32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0][3:0][31:0] mk_block(input logic [31:0] base);
        logic [3:0][3:0][31:0] m;
        for (int w = 0; w < 16; w++) m[w/4][w%4] = base + 32'(w) * 32'h01030507;
        return m;
    endfunction

    function automatic logic [31:0] exp_word(input logic [3:0][3:0][31:0] m, input int w);
        return m[w/4][w%4];
    endfunction

    function automatic logic [7:0] exp_byte(input logic [3:0][3:0][31:0] m, input int k);
        logic [31:0] wd;
        wd = m[(k/4)/4][(k/4)%4];
        return wd[8*(k%4) +: 8];
    endfunction

    task automatic reset_both();
        @(negedge clk);
        rst = 1'b0; serial_enable = 1'b0; ks_ready = 1'b0; clr_overflow = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    logic [3:0][3:0][31:0] rfc, blk_a, blk_b, blk_c, blk_d, blk_e, blk_f, blk_x;
    logic [7:0] rfc_head [4];
    logic [7:0] prev_data;
    logic       prev_ready;
    int         k;
    int         cycles;

    initial begin
        rst = 1'b0; serial_enable = 1'b0; ks_ready = 1'b0; clr_overflow = 1'b0;
        matrix = '0;
        rfc[0] = {32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};
        rfc[1] = {32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7};
        rfc[2] = {32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2};
        rfc[3] = {32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5};
        rfc_head = '{8'h10, 8'hf1, 8'he7, 8'he4};

        // Reset state, then RFC 8439 block captured on the release edge
        repeat (2) @(negedge clk);
        check("rst_valid", valid8, 0);
        check("rst_data", data8, 0);
        check("rst_last", last8, 0);
        check("rst_idx", idx8, 0);
        check("rst_accept", acc8, 1);
        check("rst_idle", idle8, 1);
        check("rst_ovf", ov8, 0);
        rst = 1'b1; matrix = rfc; serial_enable = 1'b1; ks_ready = 1'b1;
        @(negedge clk);
        serial_enable = 1'b0;
        for (int i = 0; i < 64; i++) begin
            check("rfc_valid", valid8, 1);
            check("rfc_data", data8, exp_byte(rfc, i));
            if (i < 4) check("rfc_head", data8, rfc_head[i]);
            check("rfc_last", last8, (i == 63));
            check("rfc_idx", idx8, 0);
            @(negedge clk);
        end
        check("rfc_idle", idle8, 1);
        check("rfc_valid_end", valid8, 0);

        // Two 32-bit blocks 3 cycles apart stream with no bubble
        reset_both();
        blk_a = mk_block(32'ha0000000);
        blk_b = mk_block(32'hb0000000);
        ks_ready = 1'b1; matrix = blk_a; serial_enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            serial_enable = 1'b0;
            check("b2b_valid", valid32, 1);
            check("b2b_data", data32, (i < 16) ? exp_word(blk_a, i) : exp_word(blk_b, i - 16));
            check("b2b_idx", idx32, (i < 16) ? 0 : 1);
            check("b2b_last", last32, (i == 15) || (i == 31));
            if (i == 2) begin
                matrix = blk_b; serial_enable = 1'b1;
            end
            @(negedge clk);
        end
        check("b2b_idle", idle32, 1);

        // Three strobes while stalled: third is dropped
        reset_both();
        blk_c = mk_block(32'hc0000000);
        blk_d = mk_block(32'hd0000000);
        blk_e = mk_block(32'he0000000);
        blk_f = mk_block(32'hf0000000);
        matrix = blk_c; serial_enable = 1'b1;
        @(negedge clk);
        check("ovf_accept1", acc32, 1);
        matrix = blk_d;
        @(negedge clk);
        check("ovf_accept2", acc32, 0);
        matrix = blk_e;
        @(negedge clk);
        serial_enable = 1'b0;
        check("ovf_set", ov32, 1);
        check("ovf_accept3", acc32, 0);
        check("ovf_idx0", idx32, 0);
        check("ovf_data0", data32, exp_word(blk_c, 0));
        @(negedge clk);
        check("ovf_stall", data32, exp_word(blk_c, 0));
        ks_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            check("ovf_drain_data", data32, (i < 16) ? exp_word(blk_c, i) : exp_word(blk_d, i - 16));
            check("ovf_drain_idx", idx32, (i < 16) ? 0 : 1);
            @(negedge clk);
        end
        check("ovf_idle", idle32, 1);
        check("ovf_sticky", ov32, 1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        check("ovf_clear", ov32, 0);
        matrix = blk_f; serial_enable = 1'b1;
        @(negedge clk);
        serial_enable = 1'b0;
        check("ovf_next_idx", idx32, 2);
        check("ovf_next_data", data32, exp_word(blk_f, 0));
        repeat (16) @(negedge clk);
        check("ovf_next_idle", idle32, 1);

        // Final-beat pop coincides with a strobe while full
        reset_both();
        matrix = blk_a; serial_enable = 1'b1;
        @(negedge clk);
        matrix = blk_b;
        @(negedge clk);
        serial_enable = 1'b0; ks_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("sim_data_a", data32, exp_word(blk_a, i));
            check("sim_last_a", last32, (i == 15));
            if (i == 15) begin
                matrix = blk_c; serial_enable = 1'b1;
            end
            @(negedge clk);
        end
        serial_enable = 1'b0;
        check("sim_ovf", ov32, 0);
        check("sim_accept", acc32, 0);
        for (int i = 0; i < 32; i++) begin
            check("sim_data", data32, (i < 16) ? exp_word(blk_b, i) : exp_word(blk_c, i - 16));
            check("sim_idx", idx32, (i < 16) ? 1 : 2);
            @(negedge clk);
        end
        check("sim_idle", idle32, 1);

        // Random ready, with ready already high while nothing is valid
        reset_both();
        blk_x = mk_block(32'h5a3c0f00);
        ks_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rnd_pre_valid", valid8, 0);
        matrix = blk_x; serial_enable = 1'b1;
        @(negedge clk);
        serial_enable = 1'b0;
        k = 0; cycles = 0; prev_ready = 1'b1; prev_data = '0;
        while (k < 64 && cycles < 1000) begin
            check("rnd_valid", valid8, 1);
            check("rnd_data", data8, exp_byte(blk_x, k));
            check("rnd_last", last8, (k == 63));
            if (!prev_ready) check("rnd_stable", data8, prev_data);
            prev_data = data8;
            ks_ready = 1'($urandom_range(0, 1));
            prev_ready = ks_ready;
            if (ks_ready) k++;
            @(negedge clk);
            cycles++;
        end
        check("rnd_pops", k, 64);
        check("rnd_idle", idle8, 1);

        // Reset pulsed mid-block, capture on the release edge
        reset_both();
        ks_ready = 1'b1; matrix = blk_a; serial_enable = 1'b1;
        @(negedge clk);
        serial_enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("mid_data", data8, exp_byte(blk_a, i));
            @(negedge clk);
        end
        check("mid_beat20", data8, exp_byte(blk_a, 20));
        #1 rst = 1'b0;
        #1;
        check("mid_rst_valid", valid8, 0);
        check("mid_rst_data", data8, 0);
        check("mid_rst_last", last8, 0);
        check("mid_rst_idx", idx8, 0);
        check("mid_rst_accept", acc8, 1);
        check("mid_rst_idle", idle8, 1);
        @(negedge clk);
        rst = 1'b1; matrix = blk_b; serial_enable = 1'b1;
        @(negedge clk);
        serial_enable = 1'b0;
        check("mid_new_idx", idx8, 0);
        check("mid_new_valid", valid8, 1);
        check("mid_new_data", data8, exp_byte(blk_b, 0));
        @(negedge clk);
        check("mid_new_data1", data8, exp_byte(blk_b, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
